// File: rtl/tc_clk_gate_ctrl_pkg.sv
// Shared types and sizing helpers for the clock-gate enable sequencer.
package tc_clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } ch_state_e;

  // Counter must hold max(WakeCycles, IdleCycles) - 1.
  function automatic int cnt_width(input int wake_cycles, input int idle_cycles);
    int max_c;
    max_c = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
    return ($clog2(max_c) < 1) ? 1 : $clog2(max_c);
  endfunction

  function automatic int ptr_width(input int num_ch);
    return ($clog2(num_ch) < 1) ? 1 : $clog2(num_ch);
  endfunction

  // Channel index visited at position 'off' of a round-robin scan from 'ptr'.
  function automatic int rr_index(input int ptr, input int off, input int num_ch);
    int idx;
    idx = ptr + off;
    if (idx >= num_ch) idx = idx - num_ch;
    return idx;
  endfunction

endpackage

// File: rtl/tc_clk_gate_ch.sv
// One gated channel: OFF/WAKE/ON/HOLD sequencing with a shared settle/hysteresis counter.
module tc_clk_gate_ch
  import tc_clk_gate_ctrl_pkg::*;
#(
  parameter int WakeCycles = 4,
  parameter int IdleCycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req,
  input  logic grant,
  output logic gate_en,
  output logic ack,
  output logic in_wake,
  output logic is_off
);

  localparam int CntW = cnt_width(WakeCycles, IdleCycles);
  localparam logic [CntW-1:0] WakeLoad = CntW'(WakeCycles - 1);
  localparam logic [CntW-1:0] IdleLoad = CntW'(IdleCycles - 1);

  ch_state_e       state;
  logic [CntW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      unique case (state)
        OFF: begin
          if (req && grant) begin
            state <= WAKE;
            cnt   <= WakeLoad;
          end
        end
        WAKE: begin
          if (cnt == '0) begin
            if (req) begin
              state <= ON;
            end else begin
              state <= HOLD;
              cnt   <= IdleLoad;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ON: begin
          if (!req) begin
            state <= HOLD;
            cnt   <= IdleLoad;
          end
        end
        HOLD: begin
          // A returning request beats expiry, even on the final hysteresis cycle.
          if (req) begin
            state <= ON;
          end else if (cnt == '0) begin
            state <= OFF;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= OFF;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign gate_en = (state != OFF);
  assign ack     = (state == ON);
  assign in_wake = (state == WAKE);
  assign is_off  = (state == OFF);

endmodule

// File: rtl/tc_clk_gate_ctrl.sv
// Sequences NumCh clock-gate enables with req/ack handshakes and a round-robin
// wake-up limiter. Optional macro TC_CLK_GATE_CTRL_FORCE_EN adds force_on_i.
module tc_clk_gate_ctrl
  import tc_clk_gate_ctrl_pkg::*;
#(
  parameter int NumCh      = 4,
  parameter int WakeCycles = 4,
  parameter int IdleCycles = 16,
  parameter int MaxWake    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef TC_CLK_GATE_CTRL_FORCE_EN
  input  logic             force_on_i,
`endif
  input  logic [NumCh-1:0] req_i,
  output logic [NumCh-1:0] ack_o,
  output logic [NumCh-1:0] gate_en_o,
  output logic             busy_o
);

  localparam int PtrW = ptr_width(NumCh);

  logic [NumCh-1:0] fsm_gate_en;
  logic [NumCh-1:0] in_wake;
  logic [NumCh-1:0] is_off;
  logic [NumCh-1:0] cand;
  logic [NumCh-1:0] grant;
  logic             grant_valid;
  logic [PtrW-1:0]  grant_idx;
  logic [PtrW-1:0]  rr_ptr;
  int               wake_cnt;
  int               idx;

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    tc_clk_gate_ch #(
      .WakeCycles(WakeCycles),
      .IdleCycles(IdleCycles)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req    (req_i[g]),
      .grant  (grant[g]),
      .gate_en(fsm_gate_en[g]),
      .ack    (ack_o[g]),
      .in_wake(in_wake[g]),
      .is_off (is_off[g])
    );
  end

  assign cand = is_off & req_i;

  // Slot count comes from registered state, so a channel leaving WAKE this
  // cycle still occupies its slot until the next one.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    wake_cnt    = 0;
    idx         = 0;
    for (int i = 0; i < NumCh; i++) begin
      wake_cnt = wake_cnt + int'(in_wake[i]);
    end
    if (wake_cnt < MaxWake) begin
      for (int i = 0; i < NumCh; i++) begin
        idx = rr_index(int'(rr_ptr), i, NumCh);
        if (!grant_valid && cand[PtrW'(idx)]) begin
          grant_valid = 1'b1;
          grant_idx   = PtrW'(idx);
        end
      end
    end
  end

  assign grant = grant_valid ? (NumCh'(1) << grant_idx) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (int'(grant_idx) == NumCh - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // WAKE or HOLD is exactly "gate open without ack".
  assign busy_o = |(fsm_gate_en & ~ack_o);

`ifdef TC_CLK_GATE_CTRL_FORCE_EN
  logic force_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) force_q <= 1'b0;
    else       force_q <= force_on_i;
  end

  assign gate_en_o = fsm_gate_en | {NumCh{force_q}};
`else
  assign gate_en_o = fsm_gate_en;
`endif

endmodule

// File: tb/tb_tc_clk_gate_ctrl.sv
// Directed bench for tc_clk_gate_ctrl at default parameters (4 ch, wake 4, idle 16, max wake 1).
module tb_tc_clk_gate_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] req_i;
  logic [3:0] ack_o;
  logic [3:0] gate_en_o;
  logic       busy_o;
`ifdef TC_CLK_GATE_CTRL_FORCE_EN
  logic       force_on_i = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  tc_clk_gate_ctrl dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
`ifdef TC_CLK_GATE_CTRL_FORCE_EN
    .force_on_i(force_on_i),
`endif
    .req_i    (req_i),
    .ack_o    (ack_o),
    .gate_en_o(gate_en_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance n rising edges, leaving time just past the last edge for sampling.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    req_i = 4'b0000;
    tick(2);
    tests_run++;
    if (gate_en_o !== 4'b0000 || ack_o !== 4'b0000 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: gate=%b ack=%b busy=%b, want 0000 0000 0", gate_en_o, ack_o, busy_o);
    end
    rst_i = 1'b0;
    tick(1);
  endtask

`ifdef TC_CLK_GATE_CTRL_FORCE_EN
  task automatic test_force;
    force_on_i = 1'b1;
    tick(2);
    tests_run++;
    if (gate_en_o !== 4'b1111 || ack_o !== 4'b0000) begin
      tests_failed++;
      $display("FAIL force_on: gate=%b ack=%b, want 1111 0000", gate_en_o, ack_o);
    end
    force_on_i = 1'b0;
    tick(2);
    tests_run++;
    if (gate_en_o !== 4'b0000 || ack_o !== 4'b0000) begin
      tests_failed++;
      $display("FAIL force_release: gate=%b ack=%b, want 0000 0000", gate_en_o, ack_o);
    end
  endtask
`endif

  // All four request at once; channel c is granted at edge 5c and acked at 5c+4.
  task automatic test_contention;
    logic [3:0] exp_gate;
    logic [3:0] exp_ack;
    req_i = 4'b1111;
    for (int n = 0; n < 20; n++) begin
      tick(1);
      exp_gate = '0;
      exp_ack  = '0;
      for (int c = 0; c < 4; c++) begin
        exp_gate[c] = (n >= 5 * c);
        exp_ack[c]  = (n >= 5 * c + 4);
      end
      tests_run++;
      if (gate_en_o !== exp_gate || ack_o !== exp_ack) begin
        tests_failed++;
        $display("FAIL contention_edge%0d: gate=%b ack=%b, want %b %b", n, gate_en_o, ack_o, exp_gate, exp_ack);
      end
      tests_run++;
      if ($countones(gate_en_o & ~ack_o) > 1) begin
        tests_failed++;
        $display("FAIL contention_wake_limit_edge%0d: waking=%b, want at most one bit", n, gate_en_o & ~ack_o);
      end
    end
    req_i = 4'b0000;
    tick(17);
    tests_run++;
    if (gate_en_o !== 4'b0000 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL contention_release: gate=%b busy=%b, want 0000 0", gate_en_o, busy_o);
    end
  endtask

  task automatic test_single;
    req_i = 4'b0001;
    tick(1);
    tests_run++;
    if (gate_en_o !== 4'b0001 || ack_o !== 4'b0000 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_wake: gate=%b ack=%b busy=%b, want 0001 0000 1", gate_en_o, ack_o, busy_o);
    end
    tick(3);
    tests_run++;
    if (ack_o !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_ack_early: ack=%b, want 0000", ack_o);
    end
    tick(1);
    tests_run++;
    if (ack_o !== 4'b0001 || gate_en_o !== 4'b0001 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ack: gate=%b ack=%b busy=%b, want 0001 0001 0", gate_en_o, ack_o, busy_o);
    end
    req_i = 4'b0000;
    tick(1);
    tests_run++;
    if (ack_o !== 4'b0000 || gate_en_o !== 4'b0001 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_hold: gate=%b ack=%b busy=%b, want 0001 0000 1", gate_en_o, ack_o, busy_o);
    end
    tick(15);
    tests_run++;
    if (gate_en_o !== 4'b0001 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_hold_end: gate=%b busy=%b, want 0001 1", gate_en_o, busy_o);
    end
    tick(1);
    tests_run++;
    if (gate_en_o !== 4'b0000 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_off: gate=%b busy=%b, want 0000 0", gate_en_o, busy_o);
    end
  endtask

  task automatic test_rescue;
    logic dropped;
    req_i = 4'b0010;
    tick(5);
    tests_run++;
    if (ack_o !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rescue_ack: ack=%b, want 0010", ack_o);
    end
    req_i = 4'b0000;
    dropped = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      if (gate_en_o[1] !== 1'b1) dropped = 1'b1;
      tick(1);
    end
    req_i = 4'b0010;
    tick(1);
    if (gate_en_o[1] !== 1'b1) dropped = 1'b1;
    tests_run++;
    if (ack_o !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rescue_reack: ack=%b, want 0010", ack_o);
    end
    tests_run++;
    if (dropped !== 1'b0) begin
      tests_failed++;
      $display("FAIL rescue_gate_dropped: dropped=%b, want 0", dropped);
    end
    req_i = 4'b0000;
    tick(17);
    tests_run++;
    if (gate_en_o !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rescue_off: gate=%b, want 0000", gate_en_o);
    end
  endtask

  // Pointer sits at 2 on entry; granting ch2 moves it to 3, so ch3 beats ch0.
  task automatic test_round_robin;
    req_i = 4'b0100;
    tick(1);
    req_i = 4'b1101;
    tick(4);
    tests_run++;
    if (gate_en_o !== 4'b0100 || ack_o !== 4'b0100) begin
      tests_failed++;
      $display("FAIL rr_ch2_on: gate=%b ack=%b, want 0100 0100", gate_en_o, ack_o);
    end
    tick(1);
    tests_run++;
    if (gate_en_o !== 4'b1100) begin
      tests_failed++;
      $display("FAIL rr_ch3_first: gate=%b, want 1100", gate_en_o);
    end
    tick(4);
    tests_run++;
    if (gate_en_o !== 4'b1100 || ack_o !== 4'b1100) begin
      tests_failed++;
      $display("FAIL rr_ch3_on: gate=%b ack=%b, want 1100 1100", gate_en_o, ack_o);
    end
    tick(1);
    tests_run++;
    if (gate_en_o !== 4'b1101) begin
      tests_failed++;
      $display("FAIL rr_ch0_next: gate=%b, want 1101", gate_en_o);
    end
    // ch0 drops its request mid-WAKE: it must go to HOLD without ever acking.
    req_i = 4'b0000;
    tick(5);
    tests_run++;
    if (gate_en_o !== 4'b1101 || ack_o !== 4'b0000 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rr_abort_hold: gate=%b ack=%b busy=%b, want 1101 0000 1", gate_en_o, ack_o, busy_o);
    end
    tick(20);
    tests_run++;
    if (gate_en_o !== 4'b0000 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_all_off: gate=%b busy=%b, want 0000 0", gate_en_o, busy_o);
    end
  endtask

  task automatic test_reset_mid;
    req_i = 4'b0001;
    tick(5);
    req_i = 4'b0000;
    tick(3);
    req_i = 4'b0010;
    tick(2);
    tests_run++;
    if (gate_en_o !== 4'b0011 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_setup: gate=%b busy=%b, want 0011 1", gate_en_o, busy_o);
    end
    rst_i = 1'b1;
    tick(1);
    tests_run++;
    if (gate_en_o !== 4'b0000 || ack_o !== 4'b0000 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: gate=%b ack=%b busy=%b, want 0000 0000 0", gate_en_o, ack_o, busy_o);
    end
    // Pointer is back at 0, so ch0 wins over ch2.
    rst_i = 1'b0;
    req_i = 4'b0101;
    tick(1);
    tests_run++;
    if (gate_en_o !== 4'b0001) begin
      tests_failed++;
      $display("FAIL post_reset_grant: gate=%b, want 0001", gate_en_o);
    end
    tick(4);
    tests_run++;
    if (ack_o !== 4'b0001 || gate_en_o !== 4'b0001) begin
      tests_failed++;
      $display("FAIL post_reset_ack: gate=%b ack=%b, want 0001 0001", gate_en_o, ack_o);
    end
    tick(1);
    tests_run++;
    if (gate_en_o !== 4'b0101) begin
      tests_failed++;
      $display("FAIL post_reset_ch2: gate=%b, want 0101", gate_en_o);
    end
    req_i = 4'b0000;
  endtask

  initial begin
    rst_i = 1'b1;
    req_i = 4'b0000;
    test_reset();
`ifdef TC_CLK_GATE_CTRL_FORCE_EN
    test_force();
`endif
    test_contention();
    test_single();
    test_rescue();
    test_round_robin();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
